// File: rtl/uart_rx.sv
// uart_rx: UART receiver for frames of start, 8 data bits LSB-first,
// even parity and stop. All sampling is at mid-bit.
//
// Ports
//   clk            system clock, rising edge
//   nRst           asynchronous active-low reset
//   rx_serial      asynchronous serial line, idles high
//   rx_byte        last received data byte (updated once per frame)
//   rx_ready       one-cycle strobe when a frame completes
//   parity_error   parity status of the last frame
//   framing_error  stop bit of the last frame was sampled 0
//   rx_busy        high whenever the receiver is not idle
module uart_rx #(
  parameter int Clkperbaud = 1250
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = (Clkperbaud > 2) ? $clog2(Clkperbaud) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Clkperbaud - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(Clkperbaud / 2 - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic              rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              stop_bit;
  logic              bit_tick;
  logic              mid_tick;

  // Even parity: the frame is bad when the data XOR differs from the parity bit.
  function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
    return (^d) != p;
  endfunction

  // Synchronizer stage: two flops, plus a third for falling-edge detection.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign bit_tick = (cnt == CNT_LAST);
  assign mid_tick = (cnt == CNT_MID);

  // Frame control stage: state register, baud counter and bit index.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      // The counter restarts on every state entry; START exits at mid-bit,
      // so every later full-bit tick also lands at mid-bit.
      if ((state_next != state) || (state == IDLE) || bit_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state != DATA) begin
        idx <= '0;
      end else if (bit_tick) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // A high-to-low transition is required; a line held low never starts a frame.
        if (rx_prev && !rx_sync) state_next = START;
      end
      START: begin
        if (mid_tick) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && (idx == 3'd7)) state_next = PARITY;
      end
      PARITY: begin
        if (bit_tick) state_next = STOP;
      end
      STOP: begin
        if (bit_tick) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture stage: data, parity and stop samples.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b1;
    end else begin
      if ((state == DATA) && bit_tick)   shreg[idx] <= rx_sync;
      if ((state == PARITY) && bit_tick) par_bit    <= rx_sync;
      if ((state == STOP) && bit_tick)   stop_bit   <= rx_sync;
    end
  end

  // Output stage: results load only in DONE and hold until the next DONE.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_byte       <= '0;
      rx_ready      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_ready <= (state == DONE);
      if (state == DONE) begin
        rx_byte       <= shreg;
        parity_error  <= parity_bad(shreg, par_bit);
        framing_error <= ~stop_bit;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
